// File: rtl/dsi_pkg.sv
// Shared DSI definitions for the video TX path: data-type codes, scheduler
// state encoding and the packet word-count helper.
package dsi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LINE = 3'd1,
        ST_SYNC_HDR  = 3'd2,
        ST_PIX_WAIT  = 3'd3,
        ST_PIX_HDR   = 3'd4,
        ST_PIX_DATA  = 3'd5,
        ST_LINE_DONE = 3'd6
    } state_t;

    localparam logic [5:0] DT_VSS    = 6'h01;
    localparam logic [5:0] DT_HSS    = 6'h21;
    localparam logic [5:0] DT_RGB888 = 6'h3E;

    // Long-packet word count is in bytes and carried in a 16-bit field.
    function automatic logic [15:0] byte_count(input int unsigned words);
        byte_count = 16'(words * 32'd4);
    endfunction

endpackage

// File: rtl/dsi_tx_video_timing.sv
// Free-running line timer and frame line counter for the DSI TX scheduler.
// Both are held at zero while the scheduler is idle.
module dsi_tx_video_timing
    import dsi_pkg::*;
#(
    parameter int LINE_PERIOD = 2000,
    parameter int TOTAL_LINES = 525,
    parameter int LINE_W      = 10
) (
    input  logic              clk_phy,
    input  logic              rst_phy_n,
    input  logic              i_clear,
    input  logic              i_line_adv,
    output logic              o_line_tick,
    output logic              o_timer_last,
    output logic [LINE_W-1:0] o_line_cnt
);

    localparam int TW = (LINE_PERIOD > 1) ? $clog2(LINE_PERIOD) : 1;
    localparam logic [TW-1:0]     TIMER_MAX = TW'(LINE_PERIOD - 1);
    localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(TOTAL_LINES - 1);

    logic [TW-1:0]     r_timer;
    logic [LINE_W-1:0] r_line_cnt;

    assign o_timer_last = (r_timer == TIMER_MAX);
    assign o_line_tick  = o_timer_last & ~i_clear;
    assign o_line_cnt   = r_line_cnt;

    // Line timer: wraps every LINE_PERIOD cycles, never stalls mid-frame.
    always_ff @(posedge clk_phy or negedge rst_phy_n) begin
        if (!rst_phy_n) begin
            r_timer <= '0;
        end else if (i_clear || o_timer_last) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Line counter: advanced by the scheduler, wraps at the frame end.
    always_ff @(posedge clk_phy or negedge rst_phy_n) begin
        if (!rst_phy_n) begin
            r_line_cnt <= '0;
        end else if (i_clear) begin
            r_line_cnt <= '0;
        end else if (i_line_adv) begin
            r_line_cnt <= (r_line_cnt == LINE_MAX) ? '0 : r_line_cnt + LINE_W'(1);
        end
    end

endmodule

// File: rtl/dsi_tx_line_scheduler.sv
// DSI video-mode line scheduler: emits sync/pixel headers per line and streams
// one line of payload from a show-ahead pixel buffer into the payload channel.
module dsi_tx_line_scheduler
    import dsi_pkg::*;
#(
    parameter int LINE_WORDS  = 480,
    parameter int LINE_PERIOD = 2000,
    parameter int VSA_LINES   = 2,
    parameter int VBP_LINES   = 33,
    parameter int VACT_LINES  = 480,
    parameter int VFP_LINES   = 10
) (
    input  logic        clk_phy,
    input  logic        rst_phy_n,
    input  logic        enable,
    input  logic [31:0] fifo_data,
    input  logic        fifo_not_empty,
    input  logic        fifo_line_ready,
    output logic        fifo_read_ack,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [5:0]  hdr_type,
    output logic [15:0] hdr_wc,
    output logic        pl_valid,
    input  logic        pl_ready,
    output logic [31:0] pl_data,
    output logic        pl_last,
    output logic        frame_active,
    output logic        underflow
);

    localparam int TOTAL_LINES = VSA_LINES + VBP_LINES + VACT_LINES + VFP_LINES;
    localparam int LINE_W      = (TOTAL_LINES > 1) ? $clog2(TOTAL_LINES) : 1;
    localparam int WCW         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int ACT_FIRST   = VSA_LINES + VBP_LINES;
    localparam int ACT_END     = ACT_FIRST + VACT_LINES;
    localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(TOTAL_LINES - 1);
    localparam logic [WCW-1:0]    WORD_LAST  = WCW'(LINE_WORDS - 1);
    localparam logic [15:0]       HDR_WC_PIX = byte_count(LINE_WORDS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WCW-1:0]    r_word_cnt;
    logic              r_underflow;
    logic              r_tick_pend;
    logic              w_line_tick;
    logic              w_timer_last;
    logic [LINE_W-1:0] w_line_cnt;
    logic              w_line_adv;
    logic              w_accept;
    logic              w_word_last;
    logic              w_active;
    logic              w_frame_wrap;

    dsi_tx_video_timing #(
        .LINE_PERIOD (LINE_PERIOD),
        .TOTAL_LINES (TOTAL_LINES),
        .LINE_W      (LINE_W)
    ) u_timing (
        .clk_phy      (clk_phy),
        .rst_phy_n    (rst_phy_n),
        .i_clear      (r_state == ST_IDLE),
        .i_line_adv   (w_line_adv),
        .o_line_tick  (w_line_tick),
        .o_timer_last (w_timer_last),
        .o_line_cnt   (w_line_cnt)
    );

    assign w_active     = (int'(w_line_cnt) >= ACT_FIRST) && (int'(w_line_cnt) < ACT_END);
    assign w_frame_wrap = (w_line_cnt == LINE_LAST);
    assign w_word_last  = (r_word_cnt == WORD_LAST);
    assign w_accept     = pl_valid & pl_ready;

    assign fifo_read_ack = w_accept;
    assign frame_active  = (r_state != ST_IDLE);
    assign underflow     = r_underflow;

    // Next-state decode; a tick missed outside LINE_DONE is remembered in r_tick_pend.
    always_comb begin
        w_state_nxt = r_state;
        w_line_adv  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nxt = ST_SYNC_HDR;
                else        w_state_nxt = ST_IDLE;
            end
            ST_SYNC_HDR: begin
                if (!hdr_ready)    w_state_nxt = ST_SYNC_HDR;
                else if (w_active) w_state_nxt = ST_PIX_WAIT;
                else               w_state_nxt = ST_LINE_DONE;
            end
            ST_PIX_WAIT: begin
                if (fifo_line_ready)   w_state_nxt = ST_PIX_HDR;
                else if (w_timer_last) w_state_nxt = ST_LINE_DONE;
                else                   w_state_nxt = ST_PIX_WAIT;
            end
            ST_PIX_HDR: begin
                if (hdr_ready) w_state_nxt = ST_PIX_DATA;
                else           w_state_nxt = ST_PIX_HDR;
            end
            ST_PIX_DATA: begin
                if (w_accept && w_word_last) w_state_nxt = ST_LINE_DONE;
                else                         w_state_nxt = ST_PIX_DATA;
            end
            ST_LINE_DONE: begin
                if (w_line_tick || r_tick_pend) begin
                    w_line_adv = 1'b1;
                    if (w_frame_wrap && !enable) w_state_nxt = ST_IDLE;
                    else                         w_state_nxt = ST_SYNC_HDR;
                end else begin
                    w_state_nxt = ST_LINE_DONE;
                end
            end
            ST_WAIT_LINE: w_state_nxt = ST_LINE_DONE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Channel outputs decoded from the registered state; payload is show-ahead passthrough.
    always_comb begin
        hdr_valid = 1'b0;
        hdr_type  = 6'h00;
        hdr_wc    = 16'h0000;
        pl_valid  = 1'b0;
        pl_data   = 32'h0000_0000;
        pl_last   = 1'b0;
        case (r_state)
            ST_SYNC_HDR: begin
                hdr_valid = 1'b1;
                hdr_type  = (w_line_cnt == '0) ? DT_VSS : DT_HSS;
            end
            ST_PIX_HDR: begin
                hdr_valid = 1'b1;
                hdr_type  = DT_RGB888;
                hdr_wc    = HDR_WC_PIX;
            end
            ST_PIX_DATA: begin
                pl_valid = fifo_not_empty;
                pl_data  = fifo_data;
                pl_last  = w_word_last;
            end
            default: hdr_valid = 1'b0;
        endcase
    end

    // State, word counter and sticky underflow; a PIX_WAIT timeout is also a tick outside LINE_DONE.
    always_ff @(posedge clk_phy or negedge rst_phy_n) begin
        if (!rst_phy_n) begin
            r_state     <= ST_IDLE;
            r_word_cnt  <= '0;
            r_underflow <= 1'b0;
            r_tick_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state != ST_PIX_DATA) begin
                r_word_cnt <= '0;
            end else if (w_accept) begin
                r_word_cnt <= w_word_last ? '0 : r_word_cnt + WCW'(1);
            end
            if (w_line_tick && (r_state != ST_LINE_DONE)) begin
                r_underflow <= 1'b1;
            end
            if (r_state == ST_LINE_DONE) begin
                r_tick_pend <= 1'b0;
            end else if (w_line_tick) begin
                r_tick_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dsi_tx_line_scheduler.sv
// Self-checking bench for dsi_tx_line_scheduler with a shrunk frame geometry,
// a show-ahead FIFO model and a frame-level expected header list.
module tb_dsi_tx_line_scheduler;

    localparam int P_WORDS  = 16;
    localparam int P_PERIOD = 120;
    localparam int P_VSA    = 2;
    localparam int P_VBP    = 3;
    localparam int P_VACT   = 6;
    localparam int P_VFP    = 2;
    localparam int P_TOTAL  = P_VSA + P_VBP + P_VACT + P_VFP;
    localparam int ACT0     = P_VSA + P_VBP;

    logic        clk_phy = 1'b0;
    logic        rst_phy_n;
    logic        enable;
    logic [31:0] fifo_data;
    logic        fifo_not_empty;
    logic        fifo_line_ready;
    logic        fifo_read_ack;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [5:0]  hdr_type;
    logic [15:0] hdr_wc;
    logic        pl_valid;
    logic        pl_ready;
    logic [31:0] pl_data;
    logic        pl_last;
    logic        frame_active;
    logic        underflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [21:0] hdr_q[$];
    logic [21:0] exp_hdr[$];
    logic [32:0] pl_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] data_hist[$];
    int          ack_cnt   = 0;
    int          both_cnt  = 0;
    int          hold_err  = 0;
    bit          rand_ready = 1'b0;
    bit          rand_stall = 1'b0;
    bit          rand_hdr   = 1'b0;
    bit          ack_now    = 1'b0;
    bit          prev_pend  = 1'b0;
    logic [21:0] prev_hdr   = 22'h0;

    dsi_tx_line_scheduler #(
        .LINE_WORDS  (P_WORDS),
        .LINE_PERIOD (P_PERIOD),
        .VSA_LINES   (P_VSA),
        .VBP_LINES   (P_VBP),
        .VACT_LINES  (P_VACT),
        .VFP_LINES   (P_VFP)
    ) dut (
        .clk_phy         (clk_phy),
        .rst_phy_n       (rst_phy_n),
        .enable          (enable),
        .fifo_data       (fifo_data),
        .fifo_not_empty  (fifo_not_empty),
        .fifo_line_ready (fifo_line_ready),
        .fifo_read_ack   (fifo_read_ack),
        .hdr_valid       (hdr_valid),
        .hdr_ready       (hdr_ready),
        .hdr_type        (hdr_type),
        .hdr_wc          (hdr_wc),
        .pl_valid        (pl_valid),
        .pl_ready        (pl_ready),
        .pl_data         (pl_data),
        .pl_last         (pl_last),
        .frame_active    (frame_active),
        .underflow       (underflow)
    );

    always #5 clk_phy = ~clk_phy;

    // Expected headers of one frame; skip_line is an active line with no pixel packet.
    task automatic model_frame(input int skip_line);
        for (int l = 0; l < P_TOTAL; l++) begin
            exp_hdr.push_back({(l == 0) ? 6'h01 : 6'h21, 16'h0000});
            if (l >= ACT0 && l < ACT0 + P_VACT && l != skip_line)
                exp_hdr.push_back({6'h3E, 16'(P_WORDS * 4)});
        end
    endtask

    // Monitor (negedge) plus show-ahead FIFO and ready drivers (just after posedge).
    initial begin
        logic [31:0] w;
        pl_ready       = 1'b1;
        hdr_ready      = 1'b1;
        fifo_not_empty = 1'b0;
        fifo_data      = 32'h0;
        forever begin
            @(negedge clk_phy);
            if (!rst_phy_n) begin
                ack_now   = 1'b0;
                prev_pend = 1'b0;
            end else begin
                if (prev_pend && (!hdr_valid || {hdr_type, hdr_wc} != prev_hdr)) hold_err++;
                prev_pend = hdr_valid && !hdr_ready;
                prev_hdr  = {hdr_type, hdr_wc};
                if (hdr_valid && hdr_ready) hdr_q.push_back({hdr_type, hdr_wc});
                if (pl_valid && pl_ready)   pl_q.push_back({pl_last, pl_data});
                ack_now = fifo_read_ack;
                if (ack_now) ack_cnt++;
                if (hdr_valid && pl_valid) both_cnt++;
            end
            @(posedge clk_phy);
            #1;
            if (ack_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (fifo_q.size() < 2 * P_WORDS) begin
                w = $urandom;
                fifo_q.push_back(w);
                data_hist.push_back(w);
            end
            fifo_data      = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
            fifo_not_empty = (fifo_q.size() > 0) && (!rand_stall || ($urandom_range(0, 3) != 0));
            pl_ready       = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            hdr_ready      = rand_hdr ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic test_reset();
        rst_phy_n       = 1'b0;
        enable          = 1'b0;
        fifo_line_ready = 1'b0;
        repeat (3) @(negedge clk_phy);
        n_tests++; if (hdr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hdr_valid: got %b want 0", hdr_valid); end
        n_tests++; if (pl_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pl_valid: got %b want 0", pl_valid); end
        n_tests++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL reset_frame_active: got %b want 0", frame_active); end
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b want 0", underflow); end
        n_tests++; if (fifo_read_ack !== 1'b0) begin n_fail++; $display("FAIL reset_read_ack: got %b want 0", fifo_read_ack); end
        @(posedge clk_phy); #1;
        rst_phy_n       = 1'b1;
        fifo_line_ready = 1'b1;
        repeat (4) @(negedge clk_phy);
        n_tests++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL idle_without_enable: frame_active %b want 0", frame_active); end
        n_tests++; if (hdr_q.size() != 0) begin n_fail++; $display("FAIL idle_no_headers: got %0d want 0", hdr_q.size()); end
    endtask

    task automatic test_vss_hss();
        @(posedge clk_phy); #1;
        enable = 1'b1;
        for (int c = 0; c < 4 * P_PERIOD && hdr_q.size() < 2; c++) @(posedge clk_phy);
        n_tests++;
        if (hdr_q.size() < 2) begin
            n_fail++; $display("FAIL vss_hss_timeout: got %0d headers want 2", hdr_q.size());
        end else begin
            n_tests++; if (hdr_q[0] !== {6'h01, 16'h0000}) begin n_fail++; $display("FAIL first_hdr_vss: got %h want %h", hdr_q[0], {6'h01, 16'h0000}); end
            n_tests++; if (hdr_q[1] !== {6'h21, 16'h0000}) begin n_fail++; $display("FAIL second_hdr_hss: got %h want %h", hdr_q[1], {6'h21, 16'h0000}); end
        end
        @(negedge clk_phy);
        n_tests++; if (frame_active !== 1'b1) begin n_fail++; $display("FAIL frame_active_running: got %b want 1", frame_active); end
    endtask

    task automatic test_active_line();
        for (int c = 0; c < 8 * P_PERIOD && pl_q.size() < P_WORDS; c++) @(posedge clk_phy);
        n_tests++;
        if (pl_q.size() < P_WORDS) begin
            n_fail++; $display("FAIL active_line_timeout: got %0d words want %0d", pl_q.size(), P_WORDS);
        end else begin
            for (int i = 0; i <= ACT0 + 1; i++) begin
                n_tests++; if (hdr_q[i] !== exp_hdr[i]) begin n_fail++; $display("FAIL active_hdr[%0d]: got %h want %h", i, hdr_q[i], exp_hdr[i]); end
            end
            for (int i = 0; i < P_WORDS; i++) begin
                n_tests++; if (pl_q[i] !== {(i == P_WORDS - 1), data_hist[i]}) begin n_fail++; $display("FAIL active_word[%0d]: got %h want %h", i, pl_q[i], {(i == P_WORDS - 1), data_hist[i]}); end
            end
            n_tests++; if (ack_cnt != P_WORDS) begin n_fail++; $display("FAIL active_ack_count: got %0d want %0d", ack_cnt, P_WORDS); end
        end
    endtask

    task automatic test_backpressure();
        int n_exp;
        rand_ready = 1'b1;
        rand_stall = 1'b1;
        rand_hdr   = 1'b1;
        n_exp = P_VACT * P_WORDS;
        for (int c = 0; c < 8 * P_PERIOD && pl_q.size() < n_exp; c++) @(posedge clk_phy);
        n_tests++;
        if (pl_q.size() < n_exp) begin
            n_fail++; $display("FAIL backpressure_timeout: got %0d words want %0d", pl_q.size(), n_exp);
        end else begin
            for (int i = 0; i < n_exp; i++) begin
                n_tests++; if (pl_q[i] !== {((i % P_WORDS) == P_WORDS - 1), data_hist[i]}) begin n_fail++; $display("FAIL bp_word[%0d]: got %h want %h", i, pl_q[i], {((i % P_WORDS) == P_WORDS - 1), data_hist[i]}); end
            end
        end
        for (int c = 0; c < 4 * P_PERIOD && hdr_q.size() < P_TOTAL + P_VACT + 1; c++) @(posedge clk_phy);
        rand_ready = 1'b0;
        rand_stall = 1'b0;
        rand_hdr   = 1'b0;
        n_tests++;
        if (hdr_q.size() < P_TOTAL + P_VACT + 1) begin
            n_fail++; $display("FAIL frame1_hdr_timeout: got %0d headers want %0d", hdr_q.size(), P_TOTAL + P_VACT + 1);
        end else begin
            for (int i = 0; i < P_TOTAL + P_VACT + 1; i++) begin
                n_tests++; if (hdr_q[i] !== exp_hdr[i]) begin n_fail++; $display("FAIL frame1_hdr[%0d]: got %h want %h", i, hdr_q[i], exp_hdr[i]); end
            end
        end
        n_tests++; if (ack_cnt != pl_q.size()) begin n_fail++; $display("FAIL bp_ack_count: got %0d want %0d", ack_cnt, pl_q.size()); end
        n_tests++; if (both_cnt != 0) begin n_fail++; $display("FAIL both_channels_valid: got %0d cycles want 0", both_cnt); end
        n_tests++; if (hold_err != 0) begin n_fail++; $display("FAIL hdr_hold_stable: got %0d violations want 0", hold_err); end
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL bp_no_underflow: got %b want 0", underflow); end
    endtask

    task automatic test_underflow();
        int base;
        int words_before;
        base = P_TOTAL + P_VACT;
        words_before = pl_q.size();
        fifo_line_ready = 1'b0;
        for (int c = 0; c < 8 * P_PERIOD && underflow !== 1'b1; c++) @(posedge clk_phy);
        fifo_line_ready = 1'b1;
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_set: got %b want 1", underflow); end
        n_tests++; if (pl_q.size() != words_before) begin n_fail++; $display("FAIL underflow_no_payload: got %0d words want %0d", pl_q.size(), words_before); end
        for (int c = 0; c < 3 * P_PERIOD && pl_q.size() < words_before + P_WORDS; c++) @(posedge clk_phy);
        n_tests++;
        if (pl_q.size() < words_before + P_WORDS || hdr_q.size() < base + ACT0 + 3) begin
            n_fail++; $display("FAIL recover_timeout: got %0d words want %0d", pl_q.size(), words_before + P_WORDS);
        end else begin
            for (int i = base + ACT0; i < base + ACT0 + 3; i++) begin
                n_tests++; if (hdr_q[i] !== exp_hdr[i]) begin n_fail++; $display("FAIL underflow_hdr[%0d]: got %h want %h", i, hdr_q[i], exp_hdr[i]); end
            end
            for (int i = words_before; i < words_before + P_WORDS; i++) begin
                n_tests++; if (pl_q[i] !== {((i % P_WORDS) == P_WORDS - 1), data_hist[i]}) begin n_fail++; $display("FAIL recover_word[%0d]: got %h want %h", i, pl_q[i], {((i % P_WORDS) == P_WORDS - 1), data_hist[i]}); end
            end
        end
    endtask

    task automatic test_enable_off();
        @(posedge clk_phy); #1;
        enable = 1'b0;
        for (int c = 0; c < 3 * P_TOTAL * P_PERIOD && frame_active !== 1'b0; c++) @(posedge clk_phy);
        @(negedge clk_phy);
        n_tests++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL enable_off_idle: frame_active %b want 0", frame_active); end
        n_tests++;
        if (hdr_q.size() != exp_hdr.size()) begin
            n_fail++; $display("FAIL enable_off_hdr_count: got %0d want %0d", hdr_q.size(), exp_hdr.size());
        end else begin
            for (int i = P_TOTAL + P_VACT; i < exp_hdr.size(); i++) begin
                n_tests++; if (hdr_q[i] !== exp_hdr[i]) begin n_fail++; $display("FAIL frame2_hdr[%0d]: got %h want %h", i, hdr_q[i], exp_hdr[i]); end
            end
        end
        n_tests++; if (pl_q.size() != (2 * P_VACT - 1) * P_WORDS) begin n_fail++; $display("FAIL enable_off_words: got %0d want %0d", pl_q.size(), (2 * P_VACT - 1) * P_WORDS); end
        repeat (2 * P_PERIOD) @(posedge clk_phy);
        @(negedge clk_phy);
        n_tests++; if (hdr_q.size() != exp_hdr.size()) begin n_fail++; $display("FAIL stays_idle: got %0d headers want %0d", hdr_q.size(), exp_hdr.size()); end
        n_tests++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL stays_idle_active: got %b want 0", frame_active); end
    endtask

    task automatic test_reset_mid_data();
        bit found;
        found = 1'b0;
        @(posedge clk_phy); #1;
        enable = 1'b1;
        for (int c = 0; c < 8 * P_PERIOD && !found; c++) begin
            @(posedge clk_phy); #2;
            if (pl_valid === 1'b1) found = 1'b1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL reach_pix_data: got pl_valid %b want 1", pl_valid); end
        rst_phy_n = 1'b0;
        @(negedge clk_phy);
        n_tests++; if (hdr_valid !== 1'b0 || pl_valid !== 1'b0 || fifo_read_ack !== 1'b0) begin n_fail++; $display("FAIL midreset_valids: got %b%b%b want 000", hdr_valid, pl_valid, fifo_read_ack); end
        n_tests++; if (pl_last !== 1'b0 || frame_active !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got %b%b%b want 000", pl_last, frame_active, underflow); end
        n_tests++; if (hdr_type !== 6'h00 || hdr_wc !== 16'h0000 || pl_data !== 32'h0) begin n_fail++; $display("FAIL midreset_data: got %h %h %h want 0", hdr_type, hdr_wc, pl_data); end
        enable = 1'b0;
        repeat (3) @(posedge clk_phy);
        #1;
        hdr_q.delete();
        rst_phy_n = 1'b1;
        repeat (20) @(posedge clk_phy);
        @(negedge clk_phy);
        n_tests++; if (frame_active !== 1'b0 || hdr_q.size() != 0) begin n_fail++; $display("FAIL restart_waits_enable: active %b headers %0d want 0 0", frame_active, hdr_q.size()); end
        @(posedge clk_phy); #1;
        enable = 1'b1;
        for (int c = 0; c < 10 && hdr_q.size() < 1; c++) @(posedge clk_phy);
        n_tests++;
        if (hdr_q.size() < 1) begin
            n_fail++; $display("FAIL restart_timeout: got %0d headers want 1", hdr_q.size());
        end else begin
            n_tests++; if (hdr_q[0] !== {6'h01, 16'h0000}) begin n_fail++; $display("FAIL restart_vss: got %h want %h", hdr_q[0], {6'h01, 16'h0000}); end
        end
    endtask

    initial begin
        model_frame(-1);
        model_frame(ACT0);
        test_reset();
        test_vss_hss();
        test_active_line();
        test_backpressure();
        test_underflow();
        test_enable_off();
        test_reset_mid_data();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dsi_tx_line_scheduler.md
DSI_TX_LINE_SCHEDULER -- requirements
Module: dsi_tx_line_scheduler

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 480, meaning active-line payload in 32-bit words (640 px RGB888).
REQ-002 SHALL have parameter LINE_PERIOD, default 2000, meaning clk_phy cycles per video line.
REQ-003 SHALL have parameters VSA_LINES, VBP_LINES, VACT_LINES, VFP_LINES, defaults 2, 33, 480, 10, meaning vertical sync, back porch, active and front porch line counts.
REQ-004 SHALL have port clk_phy, input, 1 bit: clock.
REQ-005 SHALL have port rst_phy_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1 bit: start and continue frame generation.
REQ-007 SHALL have ports fifo_data (input, 32 bits), fifo_not_empty (input, 1 bit), fifo_line_ready (input, 1 bit) and fifo_read_ack (output, 1 bit): show-ahead pixel buffer read side.
REQ-008 SHALL have ports hdr_valid (output, 1 bit), hdr_ready (input, 1 bit), hdr_type (output, 6 bits) and hdr_wc (output, 16 bits): packet header channel.
REQ-009 SHALL have ports pl_valid (output, 1 bit), pl_ready (input, 1 bit), pl_data (output, 32 bits) and pl_last (output, 1 bit): payload channel.
REQ-010 SHALL have ports frame_active (output, 1 bit) and underflow (output, 1 bit, sticky): status outputs.

Function
REQ-011 SHALL use FSM states IDLE, WAIT_LINE, SYNC_HDR, PIX_WAIT, PIX_HDR, PIX_DATA, LINE_DONE.
REQ-012 SHALL run a line timer 0..LINE_PERIOD-1 while not IDLE; line_tick SHALL pulse when the timer wraps to 0.
REQ-013 IDLE SHALL move to SYNC_HDR when enable=1, with line_cnt=0 and timer=0.
REQ-014 SYNC_HDR SHALL drive hdr_valid with hdr_type 0x01 (VSS) when line_cnt=0, else 0x21 (HSS), and hdr_wc=0.
REQ-015 In SYNC_HDR the FSM SHALL go to PIX_WAIT when line_cnt is in the active window [VSA+VBP, VSA+VBP+VACT), else to LINE_DONE.
REQ-016 PIX_WAIT SHALL go to PIX_HDR on fifo_line_ready=1.
REQ-017 If fifo_line_ready is still 0 when the timer reaches LINE_PERIOD-1 in PIX_WAIT, the FSM SHALL set underflow, skip the line's payload and go to LINE_DONE.
REQ-018 PIX_HDR SHALL emit hdr_type 0x3E with hdr_wc = LINE_WORDS*4 (16-bit, truncated).
REQ-019 PIX_DATA SHALL set pl_data=fifo_data and pl_valid=fifo_not_empty, and fifo_read_ack SHALL equal pl_valid & pl_ready.
REQ-020 PIX_DATA SHALL count words; pl_last SHALL be 1 on word LINE_WORDS-1; after that word is accepted the FSM SHALL go to LINE_DONE.
REQ-021 If fifo_not_empty=0 mid-line, PIX_DATA SHALL stall (pl_valid=0) without error.
REQ-022 A header SHALL complete only on hdr_valid & hdr_ready; hdr_valid, hdr_type and hdr_wc SHALL hold stable until then.
REQ-023 LINE_DONE SHALL wait for line_tick, then increment line_cnt, wrapping to 0 after VSA+VBP+VACT+VFP-1; the next state SHALL be SYNC_HDR when enable=1, else IDLE at a frame wrap.
REQ-024 Deassertion of enable SHALL take effect only at the frame boundary; the current frame SHALL complete.
REQ-025 If line_tick occurs before LINE_DONE (line overrun), the FSM SHALL finish the line and set underflow; the timer SHALL not stop.
REQ-026 frame_active SHALL be 1 in every state except IDLE.
REQ-027 The header and payload channels SHALL never be valid in the same cycle.

Reset
REQ-028 On rst_phy_n=0: state IDLE, timer=0, line_cnt=0, word count=0, underflow=0.
REQ-029 On rst_phy_n=0: all valid outputs 0, fifo_read_ack=0, pl_last=0, frame_active=0, hdr_type/hdr_wc/pl_data=0.
REQ-030 Reset mid-line SHALL abandon the packet; no output is issued until enable is sampled again.

Structure
REQ-031 Data-type codes (0x01, 0x21, 0x3E) and the state encoding SHALL live in a shared dsi_pkg package.
REQ-032 The line timer plus line_cnt SHALL be one sub-module, dsi_tx_video_timing, outputting line_tick, line_cnt and timer_last.

Verification
REQ-033 Test 1: reset, enable=1, hdr_ready=1 -> first header is 0x01 with wc 0; the next line's header is 0x21.
REQ-034 Test 2: active line, fifo_line_ready=1, pl_ready=1 -> header 0x3E with wc 1920, then 480 words with pl_last on the 480th, and 480 fifo_read_ack pulses.
REQ-035 Test 3: hold fifo_line_ready=0 through an active line -> no 0x3E header, underflow=1, next line proceeds normally.
REQ-036 Test 4: toggle pl_ready randomly at 50% -> no data dropped or duplicated, and pl_data tracks fifo_data order.
REQ-037 Test 5: deassert enable at line 100 -> lines continue to 524, then IDLE with frame_active=0.
REQ-038 Test 6: assert rst_phy_n=0 mid PIX_DATA -> all outputs 0 next cycle; restart begins with VSS.
